fp_add_seq: RTL and testbench
=============================

// Module: fp_add_seq
// PURPOSE
//  Sequencer that sits directly downstream of the 32x32 FP register memory.
//  On start it reads two IEEE-754 single-precision operands (src_a, src_b) over the memory
//  read port, adds them in a multi-cycle datapath, and writes the sum back to dst over the write port.
//  Exactly one operation is in flight at a time.
// PARAMETERS
//  AW      5    memory address width (32 words)
//  DW      32   data width, IEEE-754 binary32
//  SHMAX   26   saturation limit for the alignment right-shift distance
// PORTS
//  clk        in   1   single clock, all state on posedge
//  rst_n      in   1   asynchronous, active-low reset
//  start      in   1   request; sampled only in IDLE
//  src_a      in   AW  address of operand A, captured on accepted start
//  src_b      in   AW  address of operand B, captured on accepted start
//  dst        in   AW  result address, captured on accepted start
//  busy       out  1   high from the cycle after accept through WB
//  done       out  1   one-cycle pulse, coincident with mem_we
//  mem_re     out  1   memory read enable
//  mem_raddr  out  AW  memory read address
//  mem_rdata  in   DW  registered read data; valid the cycle after mem_re
//  mem_we     out  1   memory write enable
//  mem_waddr  out  AW  memory write address
//  mem_wdata  out  DW  memory write data
// BEHAVIOUR
//  Reset: FSM=IDLE; busy, done, mem_re, mem_we = 0; addresses, mem_wdata and all datapath regs = 0.
//  FSM: IDLE -> RD_A -> RD_B -> CAP_B -> ALIGN -> ADD -> NORM (1+k cycles) -> ROUND -> WB -> IDLE.
//   RD_A:  mem_re=1, mem_raddr=src_a.   RD_B: mem_re=1, mem_raddr=src_b; capture A from mem_rdata.
//   CAP_B: capture B.  Unpack sign/exp/24-bit mantissa; hidden bit=1 iff exp!=0.
//   ALIGN: swap so |A|>=|B|; shift B mantissa (24+3 GRS bits) right by min(expA-expB, SHMAX), sticky = OR of lost bits.
//   ADD:   same sign -> add, else subtract; 28-bit result. Carry-out -> shift right 1 (sticky kept), exp+1.
//   NORM:  zero result -> +0, skip to ROUND. Otherwise shift left 1 per cycle, exp-1, until mantissa bit23 set (k shifts).
//          exp reaching 0 -> flush to signed zero.
//   ROUND: apply rounding mode (see CONFIGURATION); mantissa overflow -> renormalize, exp+1.
//          exp >= 255 -> signed infinity.
//   WB:    mem_we=1, mem_waddr=dst, mem_wdata=result, done=1; busy drops next cycle.
//  Latency: done is high in cycle 8+k after the accepting edge.
//  Specials: denormal inputs flushed to zero. Either input NaN, or inf+(-inf) -> 0x7FC00000.
//   Single inf input -> that inf.
//  Boundaries:
//   - start while busy is ignored, not queued.
//   - src_a==src_b is legal (two reads issued).
//   - dst equal to a source is legal: reads complete before WB.
//   - mem_re and mem_we are never high in the same cycle.
//   - rst_n low mid-operation aborts immediately; no write is issued.
// CONFIGURATION
//  FP_ROUND_NEAREST_EN defined: round-to-nearest-even using guard/round/sticky.
//  Not defined: truncate (round toward zero); GRS bits discarded; latency unchanged.
// STRUCTURE
//  fp_pkg.sv: FSM state enum; field constants (EXP_W=8, MAN_W=23, BIAS=127, EXP_MAX=255);
//   canonical NaN 0x7FC00000; unpacked-operand struct {sign, exp, man}.
//  Sub-module fp_align_shift: combinational right shifter, 27-bit in, 27-bit out plus sticky, saturating at SHMAX.
// TESTING
//  Preload mem[1]=0x40C80000 (6.25), mem[2]=0xBFC00000 (-1.5); start a=1,b=2,dst=7
//   -> mem[7]=0x40980000 (4.75), done at cycle 8.
//  mem[3]=0x40980000; a=3,b=3,dst=3 -> mem[3]=0x41180000 (9.5); in-place write correct.
//  mem[8]=0xC0980000; a=3,b=8 (mem[3]=0x40980000) -> 0x00000000 via zero path; no NORM shifts.
//  mem[3]=0x40980000, mem[5]=0x40980003; a=5,b=3
//   -> 0x41180002 with FP_ROUND_NEAREST_EN, 0x41180001 without.
//  mem[9]=0x7F7FFFFF; a=9,b=9 -> 0x7F800000 (+inf).
//   mem[10]=0x7F800000, mem[11]=0xFF800000; a=10,b=11 -> 0x7FC00000.
//  Pulse start while busy -> ignored, exactly one done.
//   Drop rst_n during NORM -> busy=0, mem_we never asserted, dst unchanged.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the sequenced FP adder: FSM states, binary32 field
// constants, the canonical quiet NaN and the unpacked-operand record.
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_CAP_B,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_WB
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] expo;
    logic [MAN_W:0]   man;   // hidden bit included
  } fp_unp_t;

  // Denormals are flushed: a zero exponent yields a zero mantissa.
  function automatic fp_unp_t fp_unpack(input logic [31:0] v);
    fp_unp_t u;
    u.sign = v[31];
    u.expo = v[30:23];
    u.man  = (v[30:23] == 8'd0) ? 24'd0 : {1'b1, v[22:0]};
    return u;
  endfunction

endpackage

// File: rtl/fp_align_shift.sv
// Alignment shifter: right-shifts a 27-bit mantissa (24 bits + guard/round/
// sticky) by a distance saturated at SHMAX, reporting any bits shifted out.
module fp_align_shift #(
  parameter int SHMAX = 26
) (
  input  logic [26:0] i_man,
  input  logic [7:0]  i_dist,
  output logic [26:0] o_man,
  output logic        o_sticky
);

  logic [4:0]  w_sh;
  logic [26:0] w_mask;

  // Saturate the distance, shift, and OR together everything that fell off.
  always_comb begin
    w_sh     = (i_dist > 8'(SHMAX)) ? 5'(SHMAX) : i_dist[4:0];
    w_mask   = (27'd1 << w_sh) - 27'd1;
    o_man    = i_man >> w_sh;
    o_sticky = |(i_man & w_mask);
  end

endmodule

// File: rtl/fp_add_seq.sv
// Sequenced binary32 adder sitting on the FP register memory: reads two
// operands, adds them over several cycles, writes the sum back.
// Build option: FP_ROUND_NEAREST_EN selects round-to-nearest-even; without it
// the result is truncated (round toward zero). Latency is identical.
//
// state   | meaning
// IDLE    | waiting for start
// RD_A    | read request for operand A
// RD_B    | read request for operand B, capture A
// CAP_B   | capture B
// ALIGN   | unpack, order by magnitude, align smaller operand, detect specials
// ADD     | add/subtract mantissas, absorb carry-out
// NORM    | left-shift one bit per cycle until hidden bit set (or zero/flush)
// ROUND   | round, renormalize, overflow to infinity, pack result
// WB      | write result, pulse done
module fp_add_seq
  import fp_pkg::*;
#(
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int SHMAX = 26
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] src_a,
  input  logic [AW-1:0] src_b,
  input  logic [AW-1:0] dst,
  output logic          busy,
  output logic          done,
  output logic          mem_re,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata
);

`ifdef FP_ROUND_NEAREST_EN
  localparam logic RNE = 1'b1;
`else
  localparam logic RNE = 1'b0;
`endif

  state_t        r_state, w_next;
  logic [AW-1:0] r_src_a, r_src_b, r_dst;
  logic [DW-1:0] r_a, r_b, r_result, r_spec_val;
  logic          r_sign, r_sub, r_special, r_zero;
  logic [9:0]    r_exp;
  logic [26:0]   r_man_l, r_man_s, r_man;

  fp_unp_t       w_ua, w_ub, w_l, w_s;
  logic          w_swap, w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_spec, w_sticky;
  logic [DW-1:0] w_spec_val, w_result;
  logic [7:0]    w_dist;
  logic [26:0]   w_sh_man;
  logic [27:0]   w_sum;
  logic          w_inc;
  logic [24:0]   w_rnd;
  logic [22:0]   w_frac;
  logic [9:0]    w_exp_r;

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_WB);
  assign mem_we    = (r_state == S_WB);
  assign mem_re    = (r_state == S_RD_A) || (r_state == S_RD_B);
  assign mem_raddr = (r_state == S_RD_B) ? r_src_b : r_src_a;
  assign mem_waddr = r_dst;
  assign mem_wdata = r_result;

  // Unpack, order by magnitude and classify specials for the ALIGN step.
  always_comb begin
    w_ua     = fp_unpack(r_a);
    w_ub     = fp_unpack(r_b);
    w_swap   = {w_ub.expo, w_ub.man} > {w_ua.expo, w_ua.man};
    w_l      = w_swap ? w_ub : w_ua;
    w_s      = w_swap ? w_ua : w_ub;
    w_dist   = w_l.expo - w_s.expo;
    w_nan_a  = (r_a[30:23] == 8'hFF) && (r_a[22:0] != 23'd0);
    w_nan_b  = (r_b[30:23] == 8'hFF) && (r_b[22:0] != 23'd0);
    w_inf_a  = (r_a[30:23] == 8'hFF) && (r_a[22:0] == 23'd0);
    w_inf_b  = (r_b[30:23] == 8'hFF) && (r_b[22:0] == 23'd0);
    w_spec   = w_nan_a | w_nan_b | w_inf_a | w_inf_b;
    if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (r_a[31] != r_b[31])))
      w_spec_val = CANON_NAN;
    else if (w_inf_a)
      w_spec_val = r_a;
    else
      w_spec_val = r_b;
  end

  fp_align_shift #(.SHMAX(SHMAX)) u_align (
    .i_man    ({w_s.man, 3'b000}),
    .i_dist   (w_dist),
    .o_man    (w_sh_man),
    .o_sticky (w_sticky)
  );

  // Mantissa add/subtract; the larger magnitude is always on the left.
  always_comb begin
    if (r_sub) w_sum = {1'b0, r_man_l} - {1'b0, r_man_s};
    else       w_sum = {1'b0, r_man_l} + {1'b0, r_man_s};
  end

  // Rounding and result packing; the mantissa can carry into bit 24.
  always_comb begin
    w_inc   = RNE & r_man[2] & (r_man[1] | r_man[0] | r_man[3]);
    w_rnd   = {1'b0, r_man[26:3]} + {24'd0, w_inc};
    w_exp_r = r_exp + {9'd0, w_rnd[24]};
    w_frac  = w_rnd[24] ? w_rnd[23:1] : w_rnd[22:0];
    if (r_special)
      w_result = r_spec_val;
    else if (r_zero)
      w_result = {r_sign, 31'd0};
    else if (w_exp_r >= 10'(EXP_MAX))
      w_result = {r_sign, 8'hFF, 23'd0};
    else
      w_result = {r_sign, w_exp_r[7:0], w_frac};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RD_A;
      S_RD_A:  w_next = S_RD_B;
      S_RD_B:  w_next = S_CAP_B;
      S_CAP_B: w_next = S_ALIGN;
      S_ALIGN: w_next = S_ADD;
      S_ADD:   w_next = S_NORM;
      S_NORM:  if (r_special || (r_man == 27'd0) || r_man[26] || (r_exp <= 10'd1))
                 w_next = S_ROUND;
      S_ROUND: w_next = S_WB;
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath registers, advanced per state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src_a    <= '0;
      r_src_b    <= '0;
      r_dst      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_result   <= '0;
      r_spec_val <= '0;
      r_sign     <= 1'b0;
      r_sub      <= 1'b0;
      r_special  <= 1'b0;
      r_zero     <= 1'b0;
      r_exp      <= '0;
      r_man_l    <= '0;
      r_man_s    <= '0;
      r_man      <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_src_a <= src_a;
          r_src_b <= src_b;
          r_dst   <= dst;
        end
        S_RD_B:  r_a <= mem_rdata;
        S_CAP_B: r_b <= mem_rdata;
        S_ALIGN: begin
          r_sign     <= w_l.sign;
          r_exp      <= {2'b00, w_l.expo};
          r_man_l    <= {w_l.man, 3'b000};
          r_man_s    <= {w_sh_man[26:1], w_sh_man[0] | w_sticky};
          r_sub      <= w_l.sign ^ w_s.sign;
          r_special  <= w_spec;
          r_spec_val <= w_spec_val;
          r_zero     <= 1'b0;
        end
        S_ADD: begin
          if (w_sum[27]) begin
            r_man <= {w_sum[27:2], |w_sum[1:0]};
            r_exp <= r_exp + 10'd1;
          end else begin
            r_man <= w_sum[26:0];
          end
        end
        S_NORM: if (!r_special) begin
          if (r_man == 27'd0) begin
            // exact cancellation always yields +0
            r_zero <= 1'b1;
            r_sign <= 1'b0;
          end else if (!r_man[26]) begin
            if (r_exp <= 10'd1) r_zero <= 1'b1;
            else begin
              r_man <= {r_man[25:0], 1'b0};
              r_exp <= r_exp - 10'd1;
            end
          end
        end
        S_ROUND: r_result <= w_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_seq.sv
// Directed bench for fp_add_seq with a registered-read memory model.
module tb_fp_add_seq;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [4:0]  src_a, src_b, dst;
  logic        busy, done, mem_re, mem_we;
  logic [4:0]  mem_raddr, mem_waddr;
  logic [31:0] mem_rdata = 32'd0;
  logic [31:0] mem_wdata;

  logic [31:0] mem [0:31];
  logic        pl_en = 1'b0;
  logic [4:0]  pl_addr = 5'd0;
  logic [31:0] pl_data = 32'd0;

  int vectors = 0, miscompares = 0;
  int n_done = 0, n_we = 0, n_overlap = 0;

`ifdef FP_ROUND_NEAREST_EN
  localparam logic [31:0] EXP_RND = 32'h4118_0002;
`else
  localparam logic [31:0] EXP_RND = 32'h4118_0001;
`endif

  fp_add_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_a(src_a), .src_b(src_b), .dst(dst),
    .busy(busy), .done(done),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en)  mem[pl_addr] <= pl_data;
    if (mem_re) mem_rdata <= mem[mem_raddr];
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (done)   n_done <= n_done + 1;
    if (mem_we) n_we <= n_we + 1;
    if (mem_re && mem_we) n_overlap <= n_overlap + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issue one operation; cycle 1 is the cycle right after the accepting edge.
  task automatic run_op(input string tag, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] d, input logic [31:0] expw, input int lat);
    int  cyc;
    bit  got;
    @(negedge clk);
    src_a = a; src_b = b; dst = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; got = 0;
    check({tag, " rd_a mem_re"}, {31'd0, mem_re}, 32'd1);
    check({tag, " rd_a raddr"}, {27'd0, mem_raddr}, {27'd0, a});
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (done === 1'b1) got = 1;
    end
    check({tag, " latency"}, cyc, lat);
    check({tag, " waddr"}, {27'd0, mem_waddr}, {27'd0, d});
    @(posedge clk); #1;
    check({tag, " result"}, mem[d], expw);
    check({tag, " busy after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int nd0, nwe0, cyc;
    rst_n = 1'b0; start = 1'b0; src_a = '0; src_b = '0; dst = '0;
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    #1;
    check("reset busy",  {31'd0, busy},   32'd0);
    check("reset done",  {31'd0, done},   32'd0);
    check("reset re",    {31'd0, mem_re}, 32'd0);
    check("reset we",    {31'd0, mem_we}, 32'd0);
    check("reset raddr", {27'd0, mem_raddr}, 32'd0);
    check("reset waddr", {27'd0, mem_waddr}, 32'd0);
    check("reset wdata", mem_wdata, 32'd0);

    preload(5'd1,  32'h40C8_0000);
    preload(5'd2,  32'hBFC0_0000);
    preload(5'd3,  32'h4098_0000);
    preload(5'd5,  32'h4098_0003);
    preload(5'd8,  32'hC098_0000);
    preload(5'd9,  32'h7F7F_FFFF);
    preload(5'd10, 32'h7F80_0000);
    preload(5'd11, 32'hFF80_0000);
    preload(5'd12, 32'h3FC0_0000);
    preload(5'd13, 32'hBFA0_0000);
    preload(5'd14, 32'h7F80_0001);
    preload(5'd15, 32'h3F80_0000);
    preload(5'd16, 32'h0000_0001);
    preload(5'd20, 32'hDEAD_BEEF);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("6.25+-1.5",   5'd1,  5'd2,  5'd7,  32'h4098_0000, 8);
    run_op("in-place",    5'd3,  5'd3,  5'd3,  32'h4118_0000, 8);
    preload(5'd3, 32'h4098_0000);
    run_op("cancel",      5'd3,  5'd8,  5'd20, 32'h0000_0000, 8);
    run_op("round",       5'd5,  5'd3,  5'd21, EXP_RND,       8);
    run_op("overflow",    5'd9,  5'd9,  5'd22, 32'h7F80_0000, 8);
    run_op("inf-inf",     5'd10, 5'd11, 5'd23, 32'h7FC0_0000, 8);
    run_op("norm k=2",    5'd12, 5'd13, 5'd24, 32'h3E80_0000, 10);
    run_op("denorm",      5'd15, 5'd16, 5'd25, 32'h3F80_0000, 8);
    run_op("nan in",      5'd14, 5'd15, 5'd26, 32'h7FC0_0000, 8);
    run_op("inf+1",       5'd10, 5'd15, 5'd27, 32'h7F80_0000, 8);

    // start pulsed while busy must be dropped
    preload(5'd28, 32'h1111_1111);
    nd0 = n_done;
    @(negedge clk);
    src_a = 5'd1; src_b = 5'd2; dst = 5'd29; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk); @(negedge clk);
    src_a = 5'd3; src_b = 5'd3; dst = 5'd28; start = 1'b1;
    @(negedge clk); @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("busy-start dones", n_done - nd0, 1);
    check("busy-start dst",   mem[29], 32'h4098_0000);
    check("busy-start other", mem[28], 32'h1111_1111);

    // reset in the middle of normalization
    preload(5'd30, 32'hCAFE_F00D);
    nwe0 = n_we;
    @(negedge clk);
    src_a = 5'd12; src_b = 5'd13; dst = 5'd30; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    repeat (6) begin @(posedge clk); cyc++; end
    #1;
    rst_n = 1'b0;
    #1;
    check("abort busy", {31'd0, busy},   32'd0);
    check("abort we",   {31'd0, mem_we}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("abort no write", n_we - nwe0, 0);
    check("abort dst",      mem[30], 32'hCAFE_F00D);

    run_op("after abort", 5'd1, 5'd2, 5'd31, 32'h4098_0000, 8);
    check("re/we overlap", n_overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
